// File: rtl/led_frame_capture.sv
// led_frame_capture: rebuilds red/green frames from a row-scanned LED drive.
// A shadow buffer collects rows 0..ROWS-1 in order. The last row publishes
// the frame, the red popcount and the "unchanged" flag, all in one step.
// The consumer takes each frame through a valid/ack handshake.
module led_frame_capture #(
  parameter int ROWS = 16,
  parameter int COLS = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sample_en,
  input  logic [ROWS-1:0]            row_sel,
  input  logic [COLS-1:0]            red_n,
  input  logic [COLS-1:0]            grn_n,
  input  logic                       frame_ack,
  output logic [ROWS-1:0][COLS-1:0]  red_frame,
  output logic [ROWS-1:0][COLS-1:0]  grn_frame,
  output logic                       frame_valid,
  output logic [8:0]                 red_count,
  output logic                       frame_static,
  output logic                       overrun,
  output logic                       scan_error
);

  localparam int IDXW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [IDXW-1:0] LAST_ROW = IDXW'(ROWS - 1);

  typedef enum logic {SYNC, CAPTURE} state_t;

  state_t                    state_q, state_d;
  logic [IDXW-1:0]           expect_q, expect_d;
  logic [8:0]                acc_q, acc_d;
  logic [ROWS-1:0][COLS-1:0] shadow_red_q, shadow_red_d;
  logic [ROWS-1:0][COLS-1:0] shadow_grn_q, shadow_grn_d;
  logic [ROWS-1:0][COLS-1:0] red_frame_q, red_frame_d;
  logic [ROWS-1:0][COLS-1:0] grn_frame_q, grn_frame_d;
  logic                      valid_q, valid_d;
  logic [8:0]                count_q, count_d;
  logic                      static_q, static_d;
  logic                      have_prev_q, have_prev_d;
  logic                      overrun_q, overrun_d;
  logic                      err_q, err_d;

  logic [COLS-1:0]           red_lit, grn_lit;
  logic                      one_hot;
  logic [IDXW-1:0]           row_idx;
  logic [8:0]                row_pop;
  logic                      start_row, write_row, complete;

  // Column drives are active low; a lit pixel is a 0 on the wire.
  for (genvar gi = 0; gi < COLS; gi++) begin : g_lit
    assign red_lit[gi] = ~red_n[gi];
    assign grn_lit[gi] = ~grn_n[gi];
  end

  assign one_hot = (row_sel != '0) && ((row_sel & (row_sel - ROWS'(1))) == '0);

  // Encode the selected row; only meaningful when one_hot is set.
  always_comb begin
    row_idx = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (row_sel[r]) row_idx = IDXW'(r);
    end
  end

  // Number of lit red pixels in the incoming row.
  always_comb begin
    row_pop = '0;
    for (int c = 0; c < COLS; c++) begin
      row_pop = row_pop + {8'd0, red_lit[c]};
    end
  end

  // Scan sequencer: track the expected row, fill the shadow buffer, flag errors.
  always_comb begin
    state_d      = state_q;
    expect_d     = expect_q;
    acc_d        = acc_q;
    shadow_red_d = shadow_red_q;
    shadow_grn_d = shadow_grn_q;
    err_d        = 1'b0;
    start_row    = 1'b0;
    write_row    = 1'b0;
    complete     = 1'b0;
    case (state_q)
      SYNC: begin
        if (sample_en) begin
          if (!one_hot) err_d = 1'b1;
          else if (row_idx == '0) start_row = 1'b1;
        end
      end
      CAPTURE: begin
        if (sample_en) begin
          if (!one_hot) begin
            err_d   = 1'b1;
            state_d = SYNC;
          end else if (row_idx == expect_q) begin
            write_row = 1'b1;
            acc_d     = acc_q + row_pop;
            expect_d  = expect_q + IDXW'(1);
            if (row_idx == LAST_ROW) begin
              complete = 1'b1;
              state_d  = SYNC;
            end
          end else if (row_idx == '0) begin
            // A fresh row 0 mid-frame restarts the capture from here.
            start_row = 1'b1;
            err_d     = 1'b1;
          end else begin
            err_d   = 1'b1;
            state_d = SYNC;
          end
        end
      end
      default: state_d = SYNC;
    endcase
    if (start_row) begin
      acc_d    = row_pop;
      expect_d = IDXW'(1);
      state_d  = CAPTURE;
    end
    if (start_row || write_row) begin
      shadow_red_d[row_idx] = red_lit;
      shadow_grn_d[row_idx] = grn_lit;
    end
  end

  // Output side: publish completed frames and run the valid/ack handshake.
  always_comb begin
    red_frame_d = red_frame_q;
    grn_frame_d = grn_frame_q;
    valid_d     = valid_q;
    count_d     = count_q;
    static_d    = static_q;
    have_prev_d = have_prev_q;
    overrun_d   = overrun_q;
    if (frame_ack && valid_q) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
    if (complete) begin
      red_frame_d = shadow_red_d;
      grn_frame_d = shadow_grn_d;
      count_d     = acc_d;
      static_d    = have_prev_q && (shadow_red_d == red_frame_q);
      have_prev_d = 1'b1;
      valid_d     = 1'b1;
      // An ack in the same cycle consumes the old frame, so no overrun.
      if (valid_q && !frame_ack) overrun_d = 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= SYNC;
    else       state_q <= state_d;
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      expect_q     <= '0;
      acc_q        <= '0;
      shadow_red_q <= '0;
      shadow_grn_q <= '0;
      red_frame_q  <= '0;
      grn_frame_q  <= '0;
      valid_q      <= 1'b0;
      count_q      <= '0;
      static_q     <= 1'b0;
      have_prev_q  <= 1'b0;
      overrun_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      expect_q     <= expect_d;
      acc_q        <= acc_d;
      shadow_red_q <= shadow_red_d;
      shadow_grn_q <= shadow_grn_d;
      red_frame_q  <= red_frame_d;
      grn_frame_q  <= grn_frame_d;
      valid_q      <= valid_d;
      count_q      <= count_d;
      static_q     <= static_d;
      have_prev_q  <= have_prev_d;
      overrun_q    <= overrun_d;
      err_q        <= err_d;
    end
  end

  assign red_frame    = red_frame_q;
  assign grn_frame    = grn_frame_q;
  assign frame_valid  = valid_q;
  assign red_count    = count_q;
  assign frame_static = static_q;
  assign overrun      = overrun_q;
  assign scan_error   = err_q;

endmodule

// File: doc/led_frame_capture.md
# led_frame_capture

Receiver for the row-scanned LED matrix drive produced by the LED driver. It samples one row per strobe, rebuilds the red and green 16x16 frames, and presents each completed frame with a valid/ack handshake. It also reports the red population count and whether the red frame is unchanged from the previous one. It sits on the `clk[slow]` domain beside the driver, and serves the testbench and on-board readback.

## Interface
Parameters:
- `ROWS`, default 16: number of scanned rows. Width of `row_sel`.
- `COLS`, default 16: number of columns. Width of `red_n` and `grn_n`.

Ports:
- `clk`  in  1: the single clock. All logic is on `clk`.
- `reset`  in  1: asynchronous, active-high. Clears all state.
- `sample_en`  in  1: strobe; row data is valid this cycle.
- `row_sel`  in  ROWS: one-hot active-high row enable.
- `red_n`  in  COLS: active-low red column drive for the selected row.
- `grn_n`  in  COLS: active-low green column drive for the selected row.
- `frame_ack`  in  1: consumer acknowledges the current frame.
- `red_frame`  out  ROWS x COLS: last completed red frame, indexed `[row][col]`.
- `grn_frame`  out  ROWS x COLS: last completed green frame.
- `frame_valid`  out  1: a completed frame is held and has not been acked.
- `red_count`  out  9: number of lit red pixels in `red_frame` (0..256).
- `frame_static`  out  1: `red_frame` equals the previously completed red frame.
- `overrun`  out  1: sticky; a frame completed while the previous one was unacked.
- `scan_error`  out  1: one-cycle pulse on a malformed or out-of-order row.

## Operation
- **Decode.**
  - Pixel mapping: `frame[r][c] = ~red_n[c]` (same for green), where `r` is the index of the single set bit in `row_sel`.
  - A row is accepted only when `sample_en` is high and `row_sel` is exactly one-hot.
  - Cycles with `sample_en` low are ignored.
- **State machine: SYNC, CAPTURE.**
  - **SYNC:** wait for an accepted row 0.
    - Write it into the shadow buffer.
    - Load the row popcount into the accumulator.
    - Set `expect = 1`, go to CAPTURE.
    - Any other accepted row is ignored silently; no error.
  - **CAPTURE:** an accepted row equal to `expect` is written to the shadow buffer, its popcount is added, and `expect` increments.
    - **Frame completion:** accepting row `ROWS-1` completes the frame and returns to SYNC.
    - **Row 0 mid-frame:** an accepted row 0 seen mid-frame restarts capture. Treat it exactly as SYNC receiving row 0, and pulse `scan_error`.
    - **Other errors:** any other row not equal to `expect`, or a strobe with `row_sel` zero or multi-hot, pulses `scan_error`. Discard the partial frame and go to SYNC.
    - **Strobe in SYNC:** a zero or multi-hot strobe in SYNC also pulses `scan_error`.
- **Frame completion.**
  - Copy the shadow buffer, including the final row, to `red_frame`/`grn_frame`.
  - Load `red_count` from the accumulator plus the final row's count.
  - Set `frame_static = (new red frame == old red_frame) && have_prev`. `have_prev` is set by the first completion.
  - Set `frame_valid = 1`.
- **Handshake.**
  - `frame_ack` while `frame_valid` is high clears `frame_valid` and `overrun`.
  - `frame_ack` while `frame_valid` is low has no effect.
  - Completion while `frame_valid` is high and no ack arrives in the same cycle: overwrite the outputs, keep `frame_valid` at 1, set `overrun`.
  - Completion and ack in the same cycle: new frame latched, `frame_valid` stays 1, `overrun` cleared and not set.
- **Width rules.**
  - Row popcount is 0..COLS.
  - The accumulator is 9 bits and cannot overflow for 16x16 (maximum 256).

## Timing
- **Reset values:** all outputs 0, including frames, `red_count`, `frame_static`, `have_prev`, `overrun` and `scan_error`. State is SYNC.
- **Reset mid-frame:** the partial frame is lost; the next capture needs a fresh row 0.
- **Output registers:** all outputs are registered. Outputs update on the `clk` edge that samples row `ROWS-1`, so `frame_valid` is visible the next cycle.
- **Error pulse:** `scan_error` is high for exactly the one cycle after the offending strobe.
- **Throughput:**
  - One row per cycle is supported, with strobes back-to-back.
  - A full frame needs at least ROWS strobes.
  - Back-to-back frames with no idle cycles are supported.

## Test plan
- **Checkerboard:** after reset, scan 16 rows with `red_n` = 16'hAAAA on even rows and 16'h5555 on odd rows, `grn_n` all ones. Then:
  - `frame_valid` = 1 and `red_count` = 128.
  - `red_frame[0]` = 16'h5555, `grn_frame` all 0, `frame_static` = 0.
- **Static frame:** scan the identical frame again with ack in between → `frame_static` = 1 and `overrun` = 0. Change one pixel in row 7 → `frame_static` = 0 and `red_count` changes by ±1.
- **Overrun:** complete two frames without ack → `overrun` = 1 and `frame_valid` = 1, outputs hold the second frame. Then ack → both flags 0. Complete a frame on the same cycle as an ack → `frame_valid` = 1, `overrun` = 0.
- **Scan errors:**
  - Row order 0,1,2,4 → `scan_error` pulses one cycle after row 4; outputs are unchanged.
  - `row_sel` = 16'h0003 → `scan_error` pulses.
  - A following clean 0..15 scan completes normally.
- **Sync and restart:** start the scan at row 5 → no capture and no error until row 0 arrives. A row 0 at `expect` = 9 → `scan_error` pulses and capture restarts; a complete frame is then accepted.
- **Reset mid-frame:** assert `reset` asynchronously after row 10 → all outputs are 0 immediately. The remaining rows 11..15 produce no frame.
